// File: rtl/glyph_slot_table.sv
// CPU-written glyph slot table with end-of-field commit and a 2-cycle raster hit pipeline.
// Shadow slots take Avalon writes; the active copy drives hit detection and changes only at commit.
module glyph_slot_table #(
    parameter int NUM_SLOTS  = 8,
    parameter int GLYPH_SIZE = 16
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [3:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        end_of_field,
    output logic        glyph_show,
    output logic [3:0]  glyph_code,
    output logic [7:0]  glyph_addr
);

    localparam int          LOG_G = $clog2(GLYPH_SIZE);
    localparam logic [10:0] G11   = 11'(GLYPH_SIZE);

    logic                 r_sh_en   [NUM_SLOTS];
    logic [9:0]           r_sh_x    [NUM_SLOTS];
    logic [9:0]           r_sh_y    [NUM_SLOTS];
    logic [3:0]           r_sh_code [NUM_SLOTS];
    logic                 r_act_en  [NUM_SLOTS];
    logic [9:0]           r_act_x   [NUM_SLOTS];
    logic [9:0]           r_act_y   [NUM_SLOTS];
    logic [3:0]           r_act_code[NUM_SLOTS];
    logic                 r_pending;
    logic [15:0]          r_frame_count;
    logic [31:0]          r_readdata;

    logic [9:0]           r_px_p0, r_py_p0;
    logic [9:0]           r_px_p1, r_py_p1;
    logic [NUM_SLOTS-1:0] r_hit_p1;

    logic                 w_wr;
    logic                 w_commit;
    logic [31:0]          w_rdata;
    logic [NUM_SLOTS-1:0] w_hit;
    logic                 w_found;
    logic [3:0]           w_code;
    logic [9:0]           w_dx, w_dy;
    logic [15:0]          w_addr16;
    logic                 w_unused_ok;

    assign w_wr        = chipselect && write;
    // Commit uses pending as registered before this cycle, so a CTRL write now waits for the next field.
    assign w_commit    = end_of_field && r_pending;
    assign readdata    = r_readdata;
    assign w_unused_ok = ^{writedata[30], writedata[9:4], hcount[0]};

    always_comb begin
        w_rdata = '0;
        if (address == 4'd8)
            w_rdata = {r_frame_count, 15'd0, r_pending};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (address == 4'(i))
                w_rdata = {r_sh_en[i], 1'b0, r_sh_y[i], r_sh_x[i], 6'd0, r_sh_code[i]};
        end
    end

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_sh_en[i]    <= 1'b0;
                r_sh_x[i]     <= '0;
                r_sh_y[i]     <= '0;
                r_sh_code[i]  <= '0;
                r_act_en[i]   <= 1'b0;
                r_act_x[i]    <= '0;
                r_act_y[i]    <= '0;
                r_act_code[i] <= '0;
            end
            r_pending     <= 1'b0;
            r_frame_count <= '0;
            r_readdata    <= '0;
        end else begin
            if (end_of_field)
                r_frame_count <= r_frame_count + 16'd1;
            if (w_wr && address == 4'd8 && writedata[0])
                r_pending <= 1'b1;
            else if (w_commit)
                r_pending <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_commit) begin
                    r_act_en[i]   <= r_sh_en[i];
                    r_act_x[i]    <= r_sh_x[i];
                    r_act_y[i]    <= r_sh_y[i];
                    r_act_code[i] <= r_sh_code[i];
                end
                if (w_wr && address == 4'(i)) begin
                    r_sh_en[i]   <= writedata[31];
                    r_sh_y[i]    <= writedata[29:20];
                    r_sh_x[i]    <= writedata[19:10];
                    r_sh_code[i] <= writedata[3:0];
                end
            end
            if (chipselect && read)
                r_readdata <= w_rdata;
        end
    end

    // Stage p0 -> p1: per-slot window test with 11-bit upper bounds so x/y near 1023 never wrap.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_hit[i] = r_act_en[i]
                && (r_px_p0 >= r_act_x[i]) && ({1'b0, r_px_p0} < ({1'b0, r_act_x[i]} + G11))
                && (r_py_p0 >= r_act_y[i]) && ({1'b0, r_py_p0} < ({1'b0, r_act_y[i]} + G11));
        end
    end

    // Stage p1 -> p2: descending scan leaves the lowest hitting index as the winner.
    always_comb begin
        w_found = 1'b0;
        w_code  = '0;
        w_dx    = '0;
        w_dy    = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_hit_p1[i]) begin
                w_found = 1'b1;
                w_code  = r_act_code[i];
                w_dx    = r_px_p1 - r_act_x[i];
                w_dy    = r_py_p1 - r_act_y[i];
            end
        end
        w_addr16 = ({6'd0, w_dy} << LOG_G) | {6'd0, w_dx};
    end

    always_ff @(posedge clk50) begin
        r_px_p0 <= hcount[10:1];
        r_py_p0 <= vcount;
        r_px_p1 <= r_px_p0;
        r_py_p1 <= r_py_p0;
        if (!reset_n) begin
            r_hit_p1   <= '0;
            glyph_show <= 1'b0;
            glyph_code <= '0;
            glyph_addr <= '0;
        end else begin
            r_hit_p1   <= w_hit;
            glyph_show <= w_found;
            glyph_code <= w_code;
            glyph_addr <= w_found ? w_addr16[7:0] : 8'd0;
        end
    end

endmodule
